// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encodings, divider limits and helpers.
package uart_pkg;

    localparam int unsigned DIV_W     = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [DIV_W-1:0] UART_DIV_115200 = 16'd868;
    localparam logic [DIV_W-1:0] UART_DIV_MIN    = 16'd4;

    // Dividers below the minimum cannot centre the sample point; clamp them.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < UART_DIV_MIN) ? UART_DIV_MIN : d;
    endfunction

    // Half-bit delay from the start edge to the start-bit centre.
    function automatic logic [DIV_W-1:0] half_div(input logic [DIV_W-1:0] d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = rd_data_q;

    // Accept/commit decisions, pointer and count update, next head word.
    always_comb begin
        rd_en     = pop && !empty;
        wr_en     = push && (!full || rd_en);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head becomes the incoming byte when it lands in an empty (or emptying) FIFO.
        if (wr_en && (empty || (rd_en && count_q == CW'(1)))) begin
            rd_data_d = push_data;
        end else if (rd_en && count_q != CW'(1)) begin
            rd_data_d = mem_q[rd_ptr_q + AW'(1)];
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with a show-ahead byte FIFO and sticky framing/overrun flags.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ser_rx,
    input  logic [DIV_W-1:0]   cfg_divider,
    input  logic               rd_re,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clr
);

    logic [1:0]            sync_q, sync_d;
    logic                  rx_s;
    logic [1:0]            state_q, state_d;
    logic [DIV_W-1:0]      timer_q, timer_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  tick_c;
    logic                  push_c;
    logic                  frame_set_c;
    logic                  overrun_set_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    assign rx_s       = sync_q[1];
    assign rd_valid   = !fifo_empty;
    assign fifo_count = CNT_W'(fifo_cnt);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

    // Two-flop synchroniser for the asynchronous serial line.
    always_comb begin
        sync_d = {sync_q[0], ser_rx};
    end

    // Receiver FSM: half-bit to the start centre, then one full bit per sample.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_c      = 1'b0;
        frame_set_c = 1'b0;
        tick_c      = (timer_q == DIV_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    div_d   = clamp_div(cfg_divider);
                    timer_d = half_div(clamp_div(cfg_divider));
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d   = div_q;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    timer_d = div_q;
                    if (bit_idx_q == BIT_IDX_W'(DATA_W - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (rx_s) begin
                        push_c = 1'b1;
                    end else begin
                        frame_set_c = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_comb begin
        overrun_set_c = push_c && fifo_full && !rd_re;
        frame_err_d   = (frame_err_q && !err_clr) || frame_set_c;
        overrun_d     = (overrun_q && !err_clr) || overrun_set_c;
    end

    // State, timer, datapath and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            div_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            div_q       <= div_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (shift_q),
        .pop       (rd_re),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

endmodule
